// File: rtl/mem_bus_pkg.sv
// -----------------------------------------------------------------------------
// mem_bus_pkg
// Shared constants for the data-memory bus master and its lane aligner:
//   - bus SIZE codes (same encoding on req_size and SIZE)
//   - FSM state codes for dmem_bus_master
//   - well-known device addresses (ordinary stores as far as the bus is concerned)
//   - access legality helper
// -----------------------------------------------------------------------------
package mem_bus_pkg;

  typedef logic [1:0] mem_size_t;

  localparam mem_size_t SZ_WORD = 2'b00;
  localparam mem_size_t SZ_HALF = 2'b01;
  localparam mem_size_t SZ_BYTE = 2'b10;
  localparam mem_size_t SZ_RSVD = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic [31:0] STDOUT_ADDR = 32'hF000_0000;
  localparam logic [31:0] EXIT_ADDR   = 32'hFF00_0000;

  // Reserved size or an address not aligned to the access size.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lsb);
    case (size)
      SZ_WORD: return (addr_lsb != 2'b00);
      SZ_HALF: return addr_lsb[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bus_master_if.sv
// -----------------------------------------------------------------------------
// dmem_bus_master_if
// Control/address side of the data-memory bus. The bidirectional data bus DDT
// is kept as a plain inout on the master so the tri-state resolves at the
// netlist level.
//   DAD    [BIT_WIDTH-1:0]  data address          (master -> slave)
//   MREQ                    bus request           (master -> slave)
//   WRITE                   1 = store             (master -> slave)
//   SIZE   [1:0]            00 word/01 half/10 byte (master -> slave)
//   ACKD_n                  acknowledge, active-low (slave -> master)
// -----------------------------------------------------------------------------
interface dmem_bus_master_if #(
  parameter int BIT_WIDTH = 32
);

  logic [BIT_WIDTH-1:0] DAD;
  logic                 MREQ;
  logic                 WRITE;
  logic [1:0]           SIZE;
  logic                 ACKD_n;

  modport master (
    output DAD,
    output MREQ,
    output WRITE,
    output SIZE,
    input  ACKD_n
  );

  modport slave (
    input  DAD,
    input  MREQ,
    input  WRITE,
    input  SIZE,
    output ACKD_n
  );

endinterface

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Combinational lane placement for stores and extraction/extension for loads.
// Data is right-justified on the bus: halves live in [15:0], bytes in [7:0].
// The instruction-fetch path instantiates this with i_size = SZ_WORD.
// Ports:
//   i_size       access size code
//   i_signed     sign-extend half/byte loads
//   i_wdata      store data, right-justified
//   i_bus_rdata  raw bus data for loads
//   o_bus_wdata  store data with unused upper lanes zeroed
//   o_load_data  extended load result
// -----------------------------------------------------------------------------
module mem_lane_align
  import mem_bus_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  mem_size_t            i_size,
  input  logic                 i_signed,
  input  logic [BIT_WIDTH-1:0] i_wdata,
  input  logic [BIT_WIDTH-1:0] i_bus_rdata,
  output logic [BIT_WIDTH-1:0] o_bus_wdata,
  output logic [BIT_WIDTH-1:0] o_load_data
);

  always_comb begin
    o_bus_wdata = '0;
    o_load_data = '0;
    case (i_size)
      SZ_HALF: begin
        o_bus_wdata[15:0] = i_wdata[15:0];
        o_load_data = {{(BIT_WIDTH-16){i_signed & i_bus_rdata[15]}}, i_bus_rdata[15:0]};
      end
      SZ_BYTE: begin
        o_bus_wdata[7:0] = i_wdata[7:0];
        o_load_data = {{(BIT_WIDTH-8){i_signed & i_bus_rdata[7]}}, i_bus_rdata[7:0]};
      end
      default: begin
        o_bus_wdata = i_wdata;
        o_load_data = i_bus_rdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_bus_master.sv
// -----------------------------------------------------------------------------
// dmem_bus_master
// Processor-side initiator for the data-memory bus. Takes one load/store from
// the MEM stage, runs a single bus cycle, returns aligned/extended load data
// with a one-cycle resp_valid pulse, and stalls the pipeline meanwhile.
//
// Optional feature macro: MEMBUS_TIMEOUT_EN
//   defined   -> an access with no ack after TIMEOUT_CYCLES ACCESS cycles is
//                aborted and completes with resp_err=1
//   undefined -> ACCESS waits for ACKD_n indefinitely
//
// Ports:
//   clk, rst           clock, async active-high reset
//   req_valid/write/size/signed/addr/wdata   request from the pipeline
//   req_ready          request accepted this cycle (combinational)
//   stall              pipeline must hold
//   resp_valid         one-cycle completion pulse
//   resp_rdata         load result (0 for stores and errors)
//   resp_err           misaligned / reserved size / timeout
//   bus                DAD/MREQ/WRITE/SIZE/ACKD_n (master modport)
//   DDT                bidirectional data bus, driven only during stores
//
// state  | meaning
// IDLE   | waiting for req_valid
// ACCESS | MREQ high, waiting for ACKD_n=0 (or timeout)
// DONE   | resp_valid pulse, result on resp_rdata/resp_err
// -----------------------------------------------------------------------------
module dmem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  mem_size_t            req_size,
  input  logic                 req_signed,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 stall,
  output logic                 resp_valid,
  output logic [BIT_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  dmem_bus_master_if.master    bus,
  inout  wire  [BIT_WIDTH-1:0] DDT
);

  logic [1:0]           r_state;
  logic [BIT_WIDTH-1:0] r_addr;
  mem_size_t            r_size;
  logic                 r_write;
  logic                 r_signed;
  logic [BIT_WIDTH-1:0] r_wdata;
  logic                 r_mreq;
  logic [BIT_WIDTH-1:0] r_resp_rdata;
  logic                 r_resp_err;

  logic                 w_misaligned;
  logic [BIT_WIDTH-1:0] w_store_lanes;
  logic [BIT_WIDTH-1:0] w_load_data;

  assign w_misaligned = is_misaligned(req_size, req_addr[1:0]);

  mem_lane_align #(.BIT_WIDTH(BIT_WIDTH)) u_align (
    .i_size      (r_size),
    .i_signed    (r_signed),
    .i_wdata     (r_wdata),
    .i_bus_rdata (DDT),
    .o_bus_wdata (w_store_lanes),
    .o_load_data (w_load_data)
  );

`ifdef MEMBUS_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_tmo_cnt;

  // Held at zero outside ACCESS, so it starts from zero on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_ACCESS) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_size       <= SZ_WORD;
      r_write      <= 1'b0;
      r_signed     <= 1'b0;
      r_wdata      <= '0;
      r_mreq       <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            if (w_misaligned) begin
              // Rejected without touching the bus.
              r_state      <= ST_DONE;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= '0;
            end else begin
              r_state      <= ST_ACCESS;
              r_addr       <= req_addr;
              r_size       <= req_size;
              r_write      <= req_write;
              r_signed     <= req_signed;
              r_wdata      <= req_wdata;
              r_mreq       <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (!bus.ACKD_n) begin
            r_state      <= ST_DONE;
            r_mreq       <= 1'b0;
            r_write      <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= r_write ? '0 : w_load_data;
          end
`ifdef MEMBUS_TIMEOUT_EN
          else if (r_tmo_cnt == TMO_LAST) begin
            r_state      <= ST_DONE;
            r_mreq       <= 1'b0;
            r_write      <= 1'b0;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
          end
`endif
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // DDT enable comes straight from registers, so it releases on the same edge
  // that drops MREQ and immediately on reset.
  assign DDT = (r_mreq && r_write) ? w_store_lanes : 'z;

  assign bus.DAD   = r_addr;
  assign bus.MREQ  = r_mreq;
  assign bus.WRITE = r_write;
  assign bus.SIZE  = r_size;

  assign req_ready  = (r_state == ST_IDLE) && req_valid;
  // Low in DONE so the pipeline advances and consumes resp_rdata.
  assign stall      = (r_state == ST_ACCESS) || ((r_state == ST_IDLE) && req_valid);
  assign resp_valid = (r_state == ST_DONE);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_bus_master.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_master
// Bench for dmem_bus_master with a byte-addressed big-endian memory responder.
// DDT is pulled high when nobody drives it, so an undriven bus reads all ones.
// -----------------------------------------------------------------------------
module tb_dmem_bus_master;
  import mem_bus_pkg::*;

  localparam int TMO = 8;
  localparam logic [31:0] FLOAT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, stall, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  tri1 [31:0] ddt;
  logic        tb_drv;
  logic [31:0] tb_dat;
  assign ddt = tb_drv ? tb_dat : 32'hz;

  dmem_bus_master_if #(.BIT_WIDTH(32)) bus_if ();

  dmem_bus_master #(.BIT_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .stall      (stall),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .bus        (bus_if),
    .DDT        (ddt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [logic [31:0]];

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int n = nbytes(sz);
    longint v = 0;
    for (int i = 0; i < n; i++) v = v * 256 + longint'(mem_rd(a + 32'(i)));
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_lanes(input logic [1:0] sz, input logic [31:0] wd);
    longint v = {32'd0, wd};
    v = v % (longint'(1) << (8 * nbytes(sz)));
    return v[31:0];
  endfunction

  // Responder side: store captured bus value, build right-justified load data
  // with random junk above the addressed lanes.
  task automatic resp_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] v);
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) mem[a + 32'(i)] = 8'(v >> (8 * (n - 1 - i)));
    if (a == STDOUT_ADDR) $display("stdout: %c", v[7:0]);
    if (a == EXIT_ADDR) $display("exit store: %h", v);
  endtask

  function automatic logic [31:0] resp_load(input logic [31:0] a, input logic [1:0] sz);
    int n = nbytes(sz);
    logic [31:0] w = 32'd0;
    logic [31:0] junk = $urandom;
    for (int i = 0; i < n; i++) w = (w << 8) | {24'd0, mem_rd(a + 32'(i))};
    if (n < 4) w = w | (junk << (8 * n));
    return w;
  endfunction

  // One complete transaction with responder latency lat. Starts and ends
  // 1 time unit after a rising edge with the DUT in IDLE.
  task automatic do_access(input string nm, input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd, input int lat,
                           input logic keep_low, input logic exp_err, input logic [31:0] exp_rd);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    #1;
    chk(nm, "req_ready", req_ready, 1);
    chk(nm, "stall_req", stall, 1);
    tick();
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = $urandom;
    if (exp_err) begin
      chk(nm, "mreq_err", bus_if.MREQ, 0);
      chk(nm, "resp_valid", resp_valid, 1);
      chk(nm, "resp_err", resp_err, 1);
      chk(nm, "resp_rdata", resp_rdata, 0);
      chk(nm, "stall_done", stall, 0);
    end else begin
      for (int k = 1; k <= lat; k++) begin
        bus_if.ACKD_n = 1'b1;
        chk(nm, "mreq", bus_if.MREQ, 1);
        chk(nm, "write", bus_if.WRITE, wr);
        chk(nm, "dad", bus_if.DAD, ad);
        chk(nm, "size", bus_if.SIZE, sz);
        chk(nm, "stall_acc", stall, 1);
        chk(nm, "resp_valid_acc", resp_valid, 0);
        chk(nm, "ddt_acc", ddt, wr ? model_lanes(sz, wd) : FLOAT);
        if (k == lat) begin
          bus_if.ACKD_n = 1'b0;
          if (wr) resp_store(ad, sz, ddt);
          else begin
            tb_dat = resp_load(ad, sz);
            tb_drv = 1'b1;
          end
        end
        tick();
      end
      tb_drv = 1'b0;
      bus_if.ACKD_n = keep_low ? 1'b0 : 1'b1;
      #1;
      chk(nm, "mreq_done", bus_if.MREQ, 0);
      chk(nm, "write_done", bus_if.WRITE, 0);
      chk(nm, "ddt_done", ddt, FLOAT);
      chk(nm, "resp_valid", resp_valid, 1);
      chk(nm, "resp_err", resp_err, 0);
      chk(nm, "resp_rdata", resp_rdata, exp_rd);
      chk(nm, "stall_done", stall, 0);
    end
    tick();
    chk(nm, "resp_valid_idle", resp_valid, 0);
  endtask

  typedef struct packed {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [3:0]  lat;
    logic        keep_low;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; bus_if.ACKD_n = 1'b1; tb_drv = 1'b0; tb_dat = 32'd0;

    mem[32'h0800_0010] = 8'h12; mem[32'h0800_0011] = 8'h34;
    mem[32'h0800_0012] = 8'h56; mem[32'h0800_0013] = 8'h78;
    mem[32'h0800_0020] = 8'h80; mem[32'h0800_0021] = 8'h01;
    mem[32'h0800_0030] = 8'h80;

    //          wr    size     sg    addr            wdata          lat   keep  err   rdata
    vecs[0]  = '{1'b0, SZ_WORD, 1'b0, 32'h0800_0010, 32'h0000_0000, 4'd1, 1'b0, 1'b0, 32'h1234_5678};
    vecs[1]  = '{1'b0, SZ_HALF, 1'b1, 32'h0800_0020, 32'h0000_0000, 4'd2, 1'b0, 1'b0, 32'hFFFF_8001};
    vecs[2]  = '{1'b0, SZ_HALF, 1'b0, 32'h0800_0020, 32'h0000_0000, 4'd1, 1'b0, 1'b0, 32'h0000_8001};
    vecs[3]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0800_0030, 32'h0000_0000, 4'd2, 1'b0, 1'b0, 32'hFFFF_FF80};
    vecs[4]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0800_0030, 32'h0000_0000, 4'd1, 1'b0, 1'b0, 32'h0000_0080};
    vecs[5]  = '{1'b1, SZ_BYTE, 1'b0, 32'hF000_0000, 32'hABCD_EF41, 4'd3, 1'b0, 1'b0, 32'h0000_0000};
    vecs[6]  = '{1'b0, SZ_HALF, 1'b0, 32'h0800_0001, 32'h0000_0000, 4'd1, 1'b0, 1'b1, 32'h0000_0000};
    vecs[7]  = '{1'b0, SZ_RSVD, 1'b0, 32'h0800_0010, 32'h0000_0000, 4'd1, 1'b0, 1'b1, 32'h0000_0000};
    vecs[8]  = '{1'b1, SZ_WORD, 1'b0, 32'h0800_0012, 32'h1111_2222, 4'd1, 1'b0, 1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b1, SZ_HALF, 1'b0, 32'h0800_0040, 32'h1234_BEEF, 4'd2, 1'b1, 1'b0, 32'h0000_0000};
    vecs[10] = '{1'b0, SZ_HALF, 1'b1, 32'h0800_0040, 32'h0000_0000, 4'd3, 1'b0, 1'b0, 32'hFFFF_BEEF};
    vecs[11] = '{1'b1, SZ_WORD, 1'b0, 32'hFF00_0000, 32'hDEAD_BEEF, 4'd1, 1'b0, 1'b0, 32'h0000_0000};
    vecs[12] = '{1'b0, SZ_WORD, 1'b0, 32'hFF00_0000, 32'h0000_0000, 4'd2, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[13] = '{1'b0, SZ_BYTE, 1'b0, 32'hF000_0000, 32'h0000_0000, 4'd1, 1'b0, 1'b0, 32'h0000_0041};

    repeat (3) tick();
    chk("reset", "mreq", bus_if.MREQ, 0);
    chk("reset", "write", bus_if.WRITE, 0);
    chk("reset", "size", bus_if.SIZE, 0);
    chk("reset", "dad", bus_if.DAD, 0);
    chk("reset", "ddt", ddt, FLOAT);
    chk("reset", "req_ready", req_ready, 0);
    chk("reset", "stall", stall, 0);
    chk("reset", "resp_valid", resp_valid, 0);
    chk("reset", "resp_rdata", resp_rdata, 0);
    chk("reset", "resp_err", resp_err, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++)
      do_access($sformatf("v%0d", i), vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].ad, vecs[i].wd,
                int'(vecs[i].lat), vecs[i].keep_low, vecs[i].exp_err, vecs[i].exp_rd);

    // Reset in the middle of a store: bus released immediately, no response.
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 32'h0800_0080; req_wdata = 32'h5A5A_A5A5;
    tick();
    req_valid = 1'b0;
    bus_if.ACKD_n = 1'b1;
    tick();
    chk("rst_mid", "mreq_before", bus_if.MREQ, 1);
    chk("rst_mid", "ddt_before", ddt, 32'h5A5A_A5A5);
    rst = 1'b1;
    #1;
    chk("rst_mid", "mreq", bus_if.MREQ, 0);
    chk("rst_mid", "ddt", ddt, FLOAT);
    chk("rst_mid", "write", bus_if.WRITE, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_mid", "resp_valid_after", resp_valid, 0);
      chk("rst_mid", "mreq_after", bus_if.MREQ, 0);
    end

    // Randomized traffic in a small window so loads hit earlier stores.
    for (int i = 0; i < 40; i++) begin
      logic        wr, sg, kl, er;
      logic [1:0]  sz;
      logic [31:0] ad, wd, rd;
      int          lat;
      wr  = 1'($urandom_range(0, 1));
      sg  = 1'($urandom_range(0, 1));
      kl  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      ad  = 32'h0800_0100 + 32'($urandom_range(0, 31));
      wd  = $urandom;
      lat = $urandom_range(1, 4);
      er  = model_err(sz, ad);
      rd  = (er || wr) ? 32'd0 : model_load(sz, sg, ad);
      do_access($sformatf("r%0d", i), wr, sz, sg, ad, wd, lat, kl, er, rd);
    end

    // Responder never acknowledges.
    bus_if.ACKD_n = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 32'h0800_0010; req_wdata = 32'd0;
    tick();
    req_valid = 1'b0;
`ifdef MEMBUS_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      chk("timeout", "mreq_wait", bus_if.MREQ, 1);
      chk("timeout", "resp_valid_wait", resp_valid, 0);
      tick();
    end
    chk("timeout", "mreq", bus_if.MREQ, 0);
    chk("timeout", "ddt", ddt, FLOAT);
    chk("timeout", "resp_valid", resp_valid, 1);
    chk("timeout", "resp_err", resp_err, 1);
    chk("timeout", "resp_rdata", resp_rdata, 0);
    tick();
    chk("timeout", "resp_valid_idle", resp_valid, 0);
`else
    begin
      int hi = 0;
      int rv = 0;
      for (int k = 0; k < 100; k++) begin
        if (bus_if.MREQ) hi++;
        if (resp_valid) rv++;
        tick();
      end
      chk("no_timeout", "mreq_cycles", 32'(hi), 32'd100);
      chk("no_timeout", "resp_valid_cycles", 32'(rv), 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("no_timeout", "mreq_after_rst", bus_if.MREQ, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
